// File: rtl/fp_divider_pkg.sv
// Shared single-precision field helpers and constants for the floating-point divider.
// Inputs with a zero exponent are treated as signed zero (flush-to-zero).
package fp_divider_pkg;

    localparam logic [31:0] FP_QNAN   = 32'h7FC0_0000;
    localparam int unsigned QUOT_BITS = 26;

    function automatic logic fp_sign(input logic [31:0] x);
        return x[31];
    endfunction

    function automatic logic [7:0] fp_exp(input logic [31:0] x);
        return x[30:23];
    endfunction

    function automatic logic [23:0] fp_mant_full(input logic [31:0] x);
        return {1'b1, x[22:0]};
    endfunction

    function automatic logic is_zero(input logic [31:0] x);
        return x[30:23] == 8'h00;
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    endfunction

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic [31:0] fp_zero(input logic s);
        return {s, 31'd0};
    endfunction

    function automatic logic [31:0] fp_inf(input logic s);
        return {s, 8'hFF, 23'd0};
    endfunction

endpackage

// File: rtl/fp_divider_if.sv
// Start/done level handshake, operands, result and status flags of the divider.
interface fp_divider_if;

    logic [31:0] a;
    logic [31:0] b;
    logic        start;
    logic [31:0] result;
    logic        done;
    logic        busy;
    logic        overflow;
    logic        underflow;
    logic        div_by_zero;

    modport master (
        output a, b, start,
        input  result, done, busy, overflow, underflow, div_by_zero
    );

    modport slave (
        input  a, b, start,
        output result, done, busy, overflow, underflow, div_by_zero
    );

endinterface

// File: rtl/fp_divider_mant_div.sv
// Iterative restoring mantissa divider retiring RADIX_BITS quotient bits per cycle.
// o_last is high during the final iteration cycle; quotient/remainder are final after that edge.
module fp_divider_mant_div
    import fp_divider_pkg::*;
#(
    parameter int unsigned RADIX_BITS = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic [23:0] i_dividend,
    input  logic [23:0] i_divisor,
    output logic        o_last,
    output logic [25:0] o_quot,
    output logic        o_rem_nz
);

    localparam int unsigned NUM_ITER  = QUOT_BITS / RADIX_BITS;
    localparam logic [4:0]  ITER_INIT = 5'(NUM_ITER);

    logic [24:0] r_rem;
    logic [23:0] r_div;
    logic [25:0] r_quot;
    logic [4:0]  r_cnt;
    logic [24:0] w_rem;
    logic [25:0] w_quot;

    // Remainder stays below the divisor after each step, so the shift never loses a set bit.
    always_comb begin
        w_rem  = r_rem;
        w_quot = r_quot;
        for (int i = 0; i < RADIX_BITS; i++) begin
            if (w_rem >= {1'b0, r_div}) begin
                w_quot = {w_quot[24:0], 1'b1};
                w_rem  = w_rem - {1'b0, r_div};
            end else begin
                w_quot = {w_quot[24:0], 1'b0};
            end
            w_rem = {w_rem[23:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rem  <= '0;
            r_div  <= '0;
            r_quot <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_rem  <= {1'b0, i_dividend};
            r_div  <= i_divisor;
            r_quot <= '0;
            r_cnt  <= ITER_INIT;
        end else if (r_cnt != 5'd0) begin
            r_rem  <= w_rem;
            r_quot <= w_quot;
            r_cnt  <= r_cnt - 5'd1;
        end
    end

    assign o_last   = (r_cnt == 5'd1);
    assign o_quot   = r_quot;
    assign o_rem_nz = |r_rem;

endmodule

// File: rtl/fp_divider.sv
// IEEE-754 single-precision divider: FSM, special-case decode, normalise/round and flags.
// The mantissa quotient comes from fp_divider_mant_div.
module fp_divider
    import fp_divider_pkg::*;
#(
    parameter int unsigned RADIX_BITS = 1,
    parameter bit          ROUND_EN   = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    fp_divider_if.slave  bus
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_DIVIDE = 3'd2;
    localparam logic [2:0] ST_NORM   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    logic [2:0]        r_state;
    logic [31:0]       r_a;
    logic [31:0]       r_b;
    logic signed [9:0] r_exp;
    logic [31:0]       r_result;
    logic              r_done;
    logic              r_busy;
    logic              r_ovf;
    logic              r_unf;
    logic              r_dz;

    logic              w_sign;
    logic              w_special;
    logic              w_dz;
    logic [31:0]       w_special_res;
    logic              w_load;
    logic              w_last;
    logic [25:0]       w_quot;
    logic              w_rem_nz;
    logic [22:0]       w_mant;
    logic              w_guard;
    logic              w_sticky;
    logic              w_inc;
    logic [23:0]       w_mant_rnd;
    logic signed [9:0] w_exp_norm;
    logic signed [9:0] w_exp_fin;
    logic signed [9:0] w_exp_setup;

    assign w_sign      = fp_sign(r_a) ^ fp_sign(r_b);
    assign w_exp_setup = $signed({2'b00, fp_exp(r_a)}) - $signed({2'b00, fp_exp(r_b)}) + 10'sd127;

    always_comb begin
        w_special     = 1'b1;
        w_dz          = 1'b0;
        w_special_res = FP_QNAN;
        if (is_nan(r_a) || is_nan(r_b) || (is_zero(r_a) && is_zero(r_b)) ||
            (is_inf(r_a) && is_inf(r_b))) begin
            w_special_res = FP_QNAN;
        end else if (is_zero(r_b)) begin
            w_special_res = fp_inf(w_sign);
            w_dz          = 1'b1;
        end else if (is_inf(r_a)) begin
            w_special_res = fp_inf(w_sign);
        end else if (is_inf(r_b) || is_zero(r_a)) begin
            w_special_res = fp_zero(w_sign);
        end else begin
            w_special = 1'b0;
        end
    end

    assign w_load = (r_state == ST_SETUP) && !w_special;

    fp_divider_mant_div #(
        .RADIX_BITS (RADIX_BITS)
    ) u_mant_div (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_dividend (fp_mant_full(r_a)),
        .i_divisor  (fp_mant_full(r_b)),
        .o_last     (w_last),
        .o_quot     (w_quot),
        .o_rem_nz   (w_rem_nz)
    );

    // Quotient lies in [2^24, 2^26); a clear top bit costs one exponent step.
    always_comb begin
        if (w_quot[25]) begin
            w_mant     = w_quot[24:2];
            w_guard    = w_quot[1];
            w_sticky   = w_quot[0] | w_rem_nz;
            w_exp_norm = r_exp;
        end else begin
            w_mant     = w_quot[23:1];
            w_guard    = w_quot[0];
            w_sticky   = w_rem_nz;
            w_exp_norm = r_exp - 10'sd1;
        end
        w_inc      = ROUND_EN && w_guard && (w_sticky || w_mant[0]);
        w_mant_rnd = {1'b0, w_mant} + {23'd0, w_inc};
        w_exp_fin  = w_exp_norm + (w_mant_rnd[23] ? 10'sd1 : 10'sd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_exp    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_ovf   <= 1'b0;
                        r_unf   <= 1'b0;
                        r_dz    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (w_special) begin
                        r_result <= w_special_res;
                        r_dz     <= w_dz;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= ST_DONE;
                    end else begin
                        r_exp   <= w_exp_setup;
                        r_state <= ST_DIVIDE;
                    end
                end
                ST_DIVIDE: begin
                    if (w_last) r_state <= ST_NORM;
                end
                ST_NORM: begin
                    if (w_exp_fin >= 10'sd255) begin
                        r_result <= fp_inf(w_sign);
                        r_ovf    <= 1'b1;
                    end else if (w_exp_fin <= 10'sd0) begin
                        r_result <= fp_zero(w_sign);
                        r_unf    <= 1'b1;
                    end else begin
                        r_result <= {w_sign, w_exp_fin[7:0], w_mant_rnd[22:0]};
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    if (!bus.start) begin
                        r_done  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.result      = r_result;
    assign bus.done        = r_done;
    assign bus.busy        = r_busy;
    assign bus.overflow    = r_ovf;
    assign bus.underflow   = r_unf;
    assign bus.div_by_zero = r_dz;

endmodule
